fifo_w2n_sc: RTL and testbench



---
 rtl/fifo_w2n_sc.sv | 98 +++++++++
 tb/tb_fifo_w2n_sc.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_w2n_sc.sv
// Single-clock wide-write / narrow-read FIFO with first-word-fall-through output.
// One WR_W-bit entry per write is read back as RATIO RD_W-bit words.
module fifo_w2n_sc #(
    parameter int unsigned RD_W         = 32,
    parameter int unsigned RATIO        = 8,
    parameter int unsigned DEPTH        = 512,
    parameter int unsigned PROG_FULL_TH = 448,
    parameter bit          MSB_FIRST    = 1'b1
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic [RD_W*RATIO-1:0]                din,
    input  logic                                 wr_en,
    input  logic                                 rd_en,
    output logic [RD_W-1:0]                      dout,
    output logic                                 valid,
    output logic                                 empty,
    output logic                                 full,
    output logic                                 prog_full,
    output logic [$clog2(DEPTH*RATIO+1)-1:0]     rd_count,
    output logic                                 overflow,
    output logic                                 underflow
);

    localparam int unsigned WR_W = RD_W * RATIO;
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned EW   = $clog2(DEPTH + 1);
    localparam int unsigned SW   = $clog2(RATIO);
    localparam int unsigned CW   = $clog2(DEPTH * RATIO + 1);

    logic [WR_W-1:0] mem [DEPTH];

    logic [AW-1:0]   wp, rp, wp_n, rp_n;
    logic [EW-1:0]   ent, ent_n;
    logic [SW-1:0]   sub, sub_n, sel_n;
    logic            is_full, is_empty;
    logic            wr_acc, rd_acc, retire;
    logic [WR_W-1:0] head_n;

    // Next-state pointers; the head entry is fetched at the next read pointer so
    // dout is valid one cycle after a write and draining has no bubbles.
    always_comb begin
        is_full  = (ent == EW'(DEPTH));
        is_empty = (ent == '0);
        wr_acc   = wr_en && !is_full;
        rd_acc   = rd_en && !is_empty;
        retire   = rd_acc && (sub == SW'(RATIO - 1));
        wp_n     = wr_acc ? wp + AW'(1) : wp;
        rp_n     = retire ? rp + AW'(1) : rp;
        sub_n    = rd_acc ? sub + SW'(1) : sub;
        ent_n    = ent;
        case ({wr_acc, retire})
            2'b10:   ent_n = ent + EW'(1);
            2'b01:   ent_n = ent - EW'(1);
            default: ent_n = ent;
        endcase
        // The entry written this cycle is not yet in mem, so forward it.
        head_n = (wr_acc && (wp == rp_n)) ? din : mem[rp_n];
        sel_n  = MSB_FIRST ? ~sub_n : sub_n;
    end

    always_ff @(posedge clk) begin
        if (rstn && wr_acc) begin
            mem[wp] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wp        <= '0;
            rp        <= '0;
            ent       <= '0;
            sub       <= '0;
            dout      <= '0;
            valid     <= 1'b0;
            empty     <= 1'b1;
            full      <= 1'b0;
            prog_full <= 1'b0;
            rd_count  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wp        <= wp_n;
            rp        <= rp_n;
            ent       <= ent_n;
            sub       <= sub_n;
            dout      <= (ent_n == '0) ? '0 : head_n[32'(sel_n) * RD_W +: RD_W];
            valid     <= (ent_n != '0);
            empty     <= (ent_n == '0);
            full      <= (ent_n == EW'(DEPTH));
            prog_full <= (ent_n >= EW'(PROG_FULL_TH));
            rd_count  <= CW'({ent_n, SW'(0)}) - CW'(sub_n);
            overflow  <= overflow | (wr_en && is_full);
            underflow <= underflow | (rd_en && is_empty);
        end
    end

endmodule

// File: tb/tb_fifo_w2n_sc.sv
// Directed bench for fifo_w2n_sc: MSB-first and LSB-first instances with a
// narrow-word expectation queue built from the written patterns.
module tb_fifo_w2n_sc;

    localparam int unsigned RD_W  = 32;
    localparam int unsigned RATIO = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TH    = 3;
    localparam int unsigned WR_W  = RD_W * RATIO;
    localparam int unsigned CW    = $clog2(DEPTH * RATIO + 1);

    logic            clk = 1'b0;
    logic            rstn, wr_en, rd_en;
    logic [WR_W-1:0] din;

    logic [RD_W-1:0] m_dout, l_dout;
    logic            m_valid, m_empty, m_full, m_prog_full, m_overflow, m_underflow;
    logic            l_valid, l_empty, l_full, l_prog_full, l_overflow, l_underflow;
    logic [CW-1:0]   m_rd_count, l_rd_count;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    fifo_w2n_sc #(.RD_W(RD_W), .RATIO(RATIO), .DEPTH(DEPTH), .PROG_FULL_TH(TH), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rstn(rstn), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(m_dout), .valid(m_valid), .empty(m_empty), .full(m_full),
        .prog_full(m_prog_full), .rd_count(m_rd_count),
        .overflow(m_overflow), .underflow(m_underflow)
    );

    fifo_w2n_sc #(.RD_W(RD_W), .RATIO(RATIO), .DEPTH(DEPTH), .PROG_FULL_TH(TH), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rstn(rstn), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(l_dout), .valid(l_valid), .empty(l_empty), .full(l_full),
        .prog_full(l_prog_full), .rd_count(l_rd_count),
        .overflow(l_overflow), .underflow(l_underflow)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entry e, narrow word k (LSB-indexed) = E000_0000 | e<<8 | k
    function automatic logic [WR_W-1:0] mk(input int e);
        logic [WR_W-1:0] w;
        for (int k = 0; k < int'(RATIO); k++)
            w[k*RD_W +: RD_W] = 32'hE000_0000 | (32'(e) << 8) | 32'(k);
        return w;
    endfunction

    task automatic push_model(input logic [WR_W-1:0] d);
        for (int k = int'(RATIO) - 1; k >= 0; k--)
            q.push_back(d[k*RD_W +: RD_W]);
    endtask

    task automatic write(input logic [WR_W-1:0] d, input bit acc);
        din   = d;
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        if (acc) push_model(d);
    endtask

    task automatic drain(input int n, input string tag);
        logic [31:0] e;
        rd_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            e = q.pop_front();
            check(tag, m_dout, e);
            step();
        end
        rd_en = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_empty"},     m_empty,     1);
        check({tag, "_valid"},     m_valid,     0);
        check({tag, "_full"},      m_full,      0);
        check({tag, "_prog_full"}, m_prog_full, 0);
        check({tag, "_rd_count"},  m_rd_count,  0);
        check({tag, "_overflow"},  m_overflow,  0);
        check({tag, "_underflow"}, m_underflow, 0);
        check({tag, "_dout"},      m_dout,      0);
    endtask

    initial begin
        logic [WR_W-1:0] d;
        logic [31:0]     e;
        rstn  = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        step();
        step();
        rstn = 1'b1;
        check_reset("rst");

        // First word and sub-word order for both orderings
        for (int k = 0; k < int'(RATIO); k++) d[k*RD_W +: RD_W] = 32'(k);
        write(d, 1'b1);
        check("t1_valid", m_valid, 1);
        check("t1_first_msb", m_dout, 32'h7);
        check("t1_first_lsb", l_dout, 32'h0);
        check("t1_rd_count", m_rd_count, 8);
        rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t1_msb", m_dout, 64'(7 - i));
            check("t1_lsb", l_dout, 64'(i));
            e = q.pop_front();
            step();
        end
        rd_en = 1'b0;
        check("t1_empty", m_empty, 1);
        check("t1_rd_count0", m_rd_count, 0);
        check("t1_lsb_empty", l_empty, 1);

        // Fill, prog_full/full thresholds, dropped fifth write
        write(mk(0), 1'b1);
        check("fill_pf1", m_prog_full, 0);
        write(mk(1), 1'b1);
        check("fill_pf2", m_prog_full, 0);
        write(mk(2), 1'b1);
        check("fill_pf3", m_prog_full, 1);
        check("fill_full3", m_full, 0);
        write(mk(3), 1'b1);
        check("fill_full4", m_full, 1);
        check("fill_cnt4", m_rd_count, 32);
        check("fill_ovf_pre", m_overflow, 0);
        write(mk(9), 1'b0);
        check("fill_ovf", m_overflow, 1);
        check("fill_cnt5", m_rd_count, 32);
        drain(32, "fill_data");
        check("fill_empty", m_empty, 1);
        check("fill_full_clr", m_full, 0);
        check("fill_pf_clr", m_prog_full, 0);

        // Pointer wrap-around across many rounds
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 3; k++) write(mk(16 + r*3 + k), 1'b1);
            check("wrap_cnt", m_rd_count, 24);
            drain(24, "wrap_data");
        end
        check("wrap_empty", m_empty, 1);

        rstn = 1'b0;
        step();
        rstn = 1'b1;
        q.delete();
        check("rst2_ovf", m_overflow, 0);

        // Simultaneous write and entry-retiring read
        write(mk(40), 1'b1);
        drain(7, "sim_a");
        check("sim_cnt1", m_rd_count, 1);
        din   = mk(41);
        wr_en = 1'b1;
        rd_en = 1'b1;
        e = q.pop_front();
        check("sim_last_a", m_dout, e);
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        push_model(mk(41));
        check("sim_cnt8", m_rd_count, 8);
        check("sim_first_b", m_dout, q[0]);
        check("sim_valid", m_valid, 1);
        write(mk(42), 1'b1);
        write(mk(43), 1'b1);
        write(mk(44), 1'b1);
        check("sim_full", m_full, 1);
        drain(7, "sim_b");
        check("sim_cnt25", m_rd_count, 25);
        din   = mk(45);
        wr_en = 1'b1;
        rd_en = 1'b1;
        e = q.pop_front();
        check("sim_last_b", m_dout, e);
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("sim_ovf", m_overflow, 1);
        check("sim_cnt24", m_rd_count, 24);
        check("sim_full_clr", m_full, 0);
        drain(24, "sim_data");
        check("sim_empty", m_empty, 1);

        // Underflow is sticky and harmless
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("udf_flag", m_underflow, 1);
        check("udf_cnt", m_rd_count, 0);
        check("udf_empty", m_empty, 1);
        write(mk(50), 1'b1);
        check("udf_first", m_dout, q[0]);
        drain(8, "udf_data");
        check("udf_empty2", m_empty, 1);

        // Reset in mid-stream with requests active
        write(mk(51), 1'b1);
        write(mk(52), 1'b1);
        write(mk(53), 1'b1);
        drain(5, "mid_pre");
        check("mid_cnt19", m_rd_count, 19);
        rstn  = 1'b0;
        wr_en = 1'b1;
        rd_en = 1'b1;
        din   = mk(54);
        step();
        rstn  = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        q.delete();
        check_reset("midrst");
        for (int k = 0; k < int'(RATIO); k++) d[k*RD_W +: RD_W] = 32'hA5A5_0000 | 32'(k);
        write(d, 1'b1);
        check("mid_cnt8", m_rd_count, 8);
        drain(8, "mid_a5");
        check("mid_empty", m_empty, 1);
        check("mid_cnt0", m_rd_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
